// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - timing defaults, FSM encoding and colour-bar table shared by dvi_scan_ctrl
package dvi_pkg;

    localparam int CNT_W = 16;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    // Eight equal-width vertical bars; both pixels of a word share one colour.
    function automatic logic [63:0] bar_word(input int h, input int h_active);
        logic [23:0] rgb;
        case ((h * 8) / h_active)
            0:       rgb = 24'hFFFFFF;
            1:       rgb = 24'hFFFF00;
            2:       rgb = 24'h00FFFF;
            3:       rgb = 24'h00FF00;
            4:       rgb = 24'hFF00FF;
            5:       rgb = 24'hFF0000;
            6:       rgb = 24'h0000FF;
            default: rgb = 24'h000000;
        endcase
        return {8'h00, rgb, 8'h00, rgb};
    endfunction

endpackage

// File: rtl/dvi_scan_ctrl_if.sv
// rtl/dvi_scan_ctrl_if.sv - FIFO, control and DVI_ODDR signals of dvi_scan_ctrl (test_mode with DVI_TEST_PATTERN_EN)
interface dvi_scan_ctrl_if;

    logic        enable;
    logic [63:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [63:0] data;
    logic        offset;
    logic        border;
    logic        hs;
    logic        vs;
    logic        frame_start;
    logic        underflow;
    logic        underflow_clr;
`ifdef DVI_TEST_PATTERN_EN
    logic        test_mode;
`endif

    modport master (
        input  enable,
        input  fifo_data,
        input  fifo_empty,
        input  underflow_clr,
`ifdef DVI_TEST_PATTERN_EN
        input  test_mode,
`endif
        output fifo_rd,
        output data,
        output offset,
        output border,
        output hs,
        output vs,
        output frame_start,
        output underflow
    );

    modport slave (
        output enable,
        output fifo_data,
        output fifo_empty,
        output underflow_clr,
`ifdef DVI_TEST_PATTERN_EN
        output test_mode,
`endif
        input  fifo_rd,
        input  data,
        input  offset,
        input  border,
        input  hs,
        input  vs,
        input  frame_start,
        input  underflow
    );

endinterface

// File: rtl/dvi_raster_counter.sv
// rtl/dvi_raster_counter.sv - h/v raster counters with wrap, blanking-start load and active/sync decode
module dvi_raster_counter
    import dvi_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             active,
    output logic             in_hsync,
    output logic             in_vsync,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             h_last, v_last;

    always_comb begin
        h_last = (h_q == H_LAST);
        v_last = (v_q == V_LAST);
        h_d    = h_q;
        v_d    = v_q;
        if (clear) begin
            h_d = '0;
            v_d = '0;
        end else if (load) begin
            // Starting in vertical blanking gives the upstream FIFO time to prefill.
            h_d = '0;
            v_d = V_ACT;
        end else if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h         = h_q;
    assign v         = v_q;
    assign active    = (h_q < H_ACT) && (v_q < V_ACT);
    assign in_hsync  = (h_q >= H_SYNC_S) && (h_q < H_SYNC_E);
    assign in_vsync  = (v_q >= V_SYNC_S) && (v_q < V_SYNC_E);
    assign frame_end = h_last && v_last;

endmodule

// File: rtl/dvi_scan_ctrl.sv
// rtl/dvi_scan_ctrl.sv - DVI_ODDR scan-out sequencer fed from an FWFT pixel FIFO; DVI_TEST_PATTERN_EN adds colour bars
module dvi_scan_ctrl
    import dvi_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic            clock,
    input  logic            reset_n,
    dvi_scan_ctrl_if.master bus
);

    logic [CNT_W-1:0] h, v;
    logic             active, in_hsync, in_vsync, frame_end;
    logic             cnt_clear, cnt_load;
    scan_state_e      state_q, state_d;

    logic             scanning, want_word, pattern_on, starved;

    logic [63:0]      data_q, data_d;
    logic             offset_q, offset_d;
    logic             border_q, border_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             frame_start_q, frame_start_d;
    logic             underflow_q, underflow_d;

    dvi_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_raster (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (cnt_clear),
        .load      (cnt_load),
        .h         (h),
        .v         (v),
        .active    (active),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .frame_end (frame_end)
    );

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d  = RUN;
                    cnt_load = 1'b1;
                end else begin
                    cnt_clear = 1'b1;
                end
            end
            RUN: begin
                if (!bus.enable) state_d = DRAIN;
            end
            DRAIN: begin
                // A stopped scan still finishes the frame so the sink never sees a torn image.
                if (frame_end) state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

`ifdef DVI_TEST_PATTERN_EN
    logic test_q, test_d;

    always_comb begin
        test_d = test_q;
        if (state_q == IDLE) test_d = bus.test_mode;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) test_q <= 1'b0;
        else          test_q <= test_d;
    end

    assign pattern_on = test_q;
`else
    assign pattern_on = 1'b0;
`endif

    assign scanning    = (state_q != IDLE);
    assign want_word   = scanning && active && !h[0];
    assign bus.fifo_rd = want_word && !bus.fifo_empty && !pattern_on;
    // An empty FIFO costs the pixel pair (sent black); the raster never slips.
    assign starved     = want_word && bus.fifo_empty && !pattern_on;

    always_comb begin
        data_d = '0;
        if (want_word) begin
`ifdef DVI_TEST_PATTERN_EN
            if (pattern_on)            data_d = bar_word(int'(h), H_ACTIVE);
            else if (!bus.fifo_empty) data_d = bus.fifo_data;
`else
            if (!bus.fifo_empty) data_d = bus.fifo_data;
`endif
        end else if (scanning && active) begin
            data_d = data_q;
        end

        offset_d      = scanning && h[0];
        border_d      = !(scanning && active);
        hs_d          = (scanning && in_hsync) ? SYNC_POL : ~SYNC_POL;
        vs_d          = (scanning && in_vsync) ? SYNC_POL : ~SYNC_POL;
        frame_start_d = scanning && active && (h == '0) && (v == '0);

        underflow_d = underflow_q;
        if (bus.underflow_clr) underflow_d = 1'b0;
        if (starved)           underflow_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q        <= '0;
            offset_q      <= 1'b0;
            border_q      <= 1'b1;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            data_q        <= data_d;
            offset_q      <= offset_d;
            border_q      <= border_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.offset      = offset_q;
    assign bus.border      = border_q;
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.frame_start = frame_start_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: doc/dvi_scan_ctrl.md
Name: dvi_scan_ctrl

Overview:
Sequences the DVI ODDR output stage for one display frame at a time. Generates the raster counters and the hs/vs/border/offset controls. Pulls 64-bit two-pixel words from an upstream first-word-fall-through (FWFT) pixel FIFO and presents them to the ODDR stage's data input. Sits between the framebuffer/line-buffer FIFO and DVI_ODDR, in the same clock domain as the ODDR clock.

Parameters:
H_ACTIVE, 640, active pixels per line (must be even)
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, horizontal sync width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BP, 33, vertical back porch, lines
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clock  in  1  pixel clock, same clock as DVI_ODDR
reset_n  in  1  asynchronous active-low reset
enable  in  1  start/stop scan-out
fifo_data  in  64  FWFT head word; pixel0 in [23:0], pixel1 in [55:32]
fifo_empty  in  1  FIFO empty
fifo_rd  out  1  pop head word (combinational)
data  out  64  word to DVI_ODDR data
offset  out  1  0 = first pixel of word, 1 = second pixel
border  out  1  1 = blanking (DE low)
hs  out  1  horizontal sync
vs  out  1  vertical sync
frame_start  out  1  one-cycle pulse with the first active pixel of each frame
underflow  out  1  sticky: FIFO was empty when a word was needed
underflow_clr  in  1  clears underflow

Behaviour:
- Reset (async, immediate, including mid-frame):
  - state = IDLE, h = v = 0.
  - fifo_rd = 0, data = 0, offset = 0, border = 1, hs = vs = ~SYNC_POL.
  - frame_start = 0, underflow = 0.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; h runs 0..H_TOTAL-1 and wraps to 0.
  - V_TOTAL is defined the same way; v increments when h wraps, and wraps to 0 after V_TOTAL-1.
  - Active region: h < H_ACTIVE && v < V_ACTIVE.
  - hs is at the active level when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs uses the same rule on v.
- FSM:
  - IDLE: counters held at 0, outputs at reset values. When enable is sampled high, go to RUN with h = 0, v = V_ACTIVE. Scan-out starts in vertical blanking so the FIFO can prefill.
  - RUN: counters advance every cycle. If enable is sampled low, go to DRAIN.
  - DRAIN: counters keep advancing. When v wraps to 0 (frame complete), go to IDLE. enable re-asserted during DRAIN is ignored until IDLE is reached.
- Read handshake:
  - fifo_rd = (state != IDLE) && active && h[0] == 0 && !fifo_empty.
  - On fifo_rd, data <= fifo_data at the same edge. data holds for the following odd pixel.
  - If a word is needed (active, even h) and fifo_empty is high: no pop, data <= 0 (black pair), underflow <= 1. The pair is skipped, not delayed.
- Output registers:
  - offset <= h[0], border <= ~active, hs, vs are registered at the same edge as data, so all DVI_ODDR inputs are cycle-aligned.
  - Latency: counter state to outputs is 1 cycle.
- frame_start <= active && h == 0 && v == 0.
- underflow:
  - Set has priority over underflow_clr in the same cycle.
  - Cleared only by underflow_clr or reset.
- FIFO words consumed per frame = V_ACTIVE*H_ACTIVE/2. Zero reads occur during blanking.

Optional Feature:
DVI_TEST_PATTERN_EN
- Defined: adds input test_mode (1 bit).
  - When test_mode = 1, fifo_rd is held at 0 and data carries 8 vertical colour bars, selected by h*8/H_ACTIVE. Both pixels in a word are the same colour. underflow is never set.
  - test_mode is sampled only in IDLE.
- Not defined: no test_mode port; data always comes from the FIFO.

Decomposition:
- Shared package dvi_pkg:
  - default timing constants (640x480 set)
  - derived H_TOTAL/V_TOTAL
  - FSM state encoding (IDLE, RUN, DRAIN)
  - colour-bar table
- One sub-module, dvi_raster_counter:
  - h/v counters with wrap, load-to-(0,V_ACTIVE), active/hs/vs decode
  - parameterised by timing

Test Plan:
Bench uses H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), SYNC_POL 0, FIFO always non-empty.
1. Enable sampled at edge E0 -> border first 0 at edge E43. frame_start pulses at E43 only. offset pattern 0,1,0,1... for 8 cycles, then border = 1.
2. Full frame -> exactly 16 fifo_rd pulses, each on an even active pixel. hs low 2 cycles per line starting at h = 10. vs low 14 cycles starting at v = 5, h = 0.
3. FIFO words 0x...AA, 0x...BB -> data equals each word for exactly 2 consecutive cycles, aligned with offset 0 then 1.
4. fifo_empty forced high for one even active pixel -> no fifo_rd, data = 0 for 2 cycles, underflow = 1. underflow_clr pulsed in the same cycle as a new underflow -> underflow remains 1.
5. enable dropped mid-frame at v = 2 -> scan-out continues to the end of frame, returns to IDLE at the v wrap, border = 1, no further fifo_rd.
6. reset_n pulsed low mid active line -> all outputs at reset values immediately, without waiting for a clock edge. After release with enable high, the scan-out restarts with the 43-cycle start-up sequence.
